eq_cmp_scheduler: RTL
=====================

// Module: eq_cmp_scheduler
// PURPOSE
//  Time-shares one registered equality comparator among NREQ requesters. Each requester
//  offers an operand pair over valid/ready. A round-robin arbiter grants one pair per
//  transaction, a small FSM sequences latch -> compare -> respond, and the result is
//  returned with the requester ID. Sits in front of the x1==x2 match-pulse datapath.
// PARAMETERS
//  NREQ  4  number of requesters (2..16)
//  W     8  operand width in bits (1..32)
//  IDW   $clog2(NREQ)  width of requester ID (derived localparam, not overridable)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  req_valid  in   NREQ     per-requester operand pair valid
//  req_a      in   NREQ*W   operand A; requester i occupies bits [i*W +: W]
//  req_b      in   NREQ*W   operand B; same packing as req_a
//  req_ready  out  NREQ     one-hot grant/accept; at most one bit high
//  res_valid  out  1        result available
//  res_ready  in   1        result consumer accepts
//  res_match  out  1        1 = operands of granted pair were equal
//  res_id     out  IDW      index of requester whose result is presented
//  busy       out  1        high in any state other than IDLE
//  cmp_mask   in   W        only with CMP_MASK_EN: per-bit compare enable
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, res_valid=0, res_match=0, res_id=0, busy=0.
//  Reset mid-transaction discards latched operands; no result is produced for them.
//  Reset deassertion is synchronised externally; the block has no internal synchroniser.
//  FSM states: IDLE, EVAL, RESP.
//   IDLE: winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, .. mod NREQ.
//         req_ready[winner]=1 (combinational from req_valid and rr_ptr); all other bits 0.
//         On handshake: latch a, b, id=winner; rr_ptr <= (winner+1) mod NREQ; -> EVAL.
//         No req_valid set: stay IDLE, req_ready=0.
//   EVAL: res_match_q <= (a_q == b_q); -> RESP. req_ready=0.
//   RESP: res_valid=1 with res_match and res_id stable; req_ready=0.
//         res_ready=1: -> IDLE; res_valid drops in the next cycle.
//         res_ready=0: hold RESP and keep all result outputs unchanged (no timeout).
//  Latency: handshake in cycle T -> res_valid=1 in cycle T+2. Minimum 3 cycles per grant.
//  Operands latched at grant; later changes on req_a/req_b do not affect the result.
//  res_match and res_id keep their last values outside RESP; qualify them with res_valid.
//  Back-to-back: a requester granted in IDLE has lowest priority next round if others are valid.
//  Single requester constantly valid: granted every 3 cycles (with res_ready held 1).
//  A requester dropping req_valid while not granted is simply skipped; no state retained.
//  rr_ptr wraps NREQ-1 -> 0. IDs are zero-based; NREQ not a power of 2 must never yield ID>=NREQ.
// CONFIGURATION
//  CMP_MASK_EN defined: cmp_mask port present; sampled in EVAL;
//   res_match = ((a_q ^ b_q) & cmp_mask) == 0; all-zero mask always yields match=1.
//  CMP_MASK_EN undefined: no cmp_mask port; res_match = (a_q == b_q) over all W bits.
// TESTING
//  1) rst=1 mid-RESP -> res_valid=0, busy=0, req_ready=0 immediately; rr_ptr=0 after release.
//  2) req_valid=4'b0001, a0=8'h5A, b0=8'h5A, res_ready=1 -> req_ready=4'b0001 at T,
//     res_valid at T+2, res_match=1, res_id=0.
//  3) req_valid=4'b1111 held, res_ready=1, all pairs unequal -> grant order 0,1,2,3,0;
//     res_id sequence 0,1,2,3,0; res_match=0 on each result.
//  4) Grant id 2 with a=8'h10, b=8'h10; res_ready=0 for 5 cycles -> res_valid, res_match=1
//     and res_id=2 stable; req_ready=0 throughout; then res_ready=1 -> IDLE next cycle.
//  5) Change a2 to 8'hFF the cycle after the grant -> res_match still 1 (latched operands).
//  6) CMP_MASK_EN: a=8'hA5, b=8'hA4, cmp_mask=8'hFE -> res_match=1; cmp_mask=8'hFF -> 0.

Source files
------------

// File: rtl/eq_cmp_scheduler.sv
// eq_cmp_scheduler: shares one registered equality comparator among NREQ
// requesters. A round-robin arbiter grants one operand pair at a time. A
// three-state FSM (IDLE -> EVAL -> RESP) latches the pair, compares it and
// presents the result with the requester ID.
// Optional feature: define CMP_MASK_EN to add the cmp_mask port, which gives
// a per-bit compare enable.
module eq_cmp_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_match,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic                      busy
`ifdef CMP_MASK_EN
  ,
  input  logic [W-1:0]              cmp_mask
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [IDW-1:0] id_q, id_d;
  logic           res_match_q, res_match_d;
  logic [IDW-1:0] res_id_q, res_id_d;

  logic           found;
  logic [IDW-1:0] winner;
  logic           grant;

  // Round-robin search starting at rr_ptr. The scan runs backwards, so the
  // closest valid requester at or after the pointer is the last one written.
  // The modulo keeps every candidate below NREQ, even when NREQ is not a
  // power of two.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // The grant is qualified by reset so that req_ready reads zero while
  // reset is held.
  assign grant = found && !rst && (state_q == IDLE);

  // Next-state logic plus the capture of operands and results for each
  // FSM state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    res_match_d = res_match_q;
    res_id_d    = res_id_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          req_ready[winner] = 1'b1;
          a_d      = req_a[int'(winner)*W +: W];
          b_d      = req_b[int'(winner)*W +: W];
          id_d     = winner;
          rr_ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
          state_d  = EVAL;
        end
      end
      EVAL: begin
`ifdef CMP_MASK_EN
        res_match_d = (((a_q ^ b_q) & cmp_mask) == '0);
`else
        res_match_d = (a_q == b_q);
`endif
        res_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Asynchronous reset discards any
  // transaction that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      res_match_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      res_match_q <= res_match_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign res_match = res_match_q;
  assign res_id    = res_id_q;

endmodule
